// File: rtl/set_multi_eval_pkg.sv
// Shared types, defaults and helpers for the set-evaluation engine.
package set_pkg;

  // Job sequencing states of the top-level controller.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_NCIRC   = 3;
  localparam int DEF_COORD_W = 4;
  localparam int DEF_GRID    = 8;
  localparam int DEF_LANES   = 4;
  localparam int DEF_CNT_W   = 8;

  // Smallest w such that 2^w >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/set_multi_eval_circle_hit.sv
// Combinational test of one lattice point against one circle.
// The point is inside when (px-cx)^2 + (py-cy)^2 <= r^2, computed
// with full-width signed differences and untruncated squares.
module circle_hit #(
  parameter int COORD_W = 4
) (
  input  logic [COORD_W-1:0] i_px,
  input  logic [COORD_W-1:0] i_py,
  input  logic [COORD_W-1:0] i_cx,
  input  logic [COORD_W-1:0] i_cy,
  input  logic [COORD_W-1:0] i_r,
  output logic               o_hit
);

  localparam int SQ_W = 2 * COORD_W + 3;

  logic signed [COORD_W:0] w_dx;
  logic signed [COORD_W:0] w_dy;
  logic        [COORD_W:0] w_adx;
  logic        [COORD_W:0] w_ady;
  logic        [SQ_W-1:0]  w_dist;
  logic        [SQ_W-1:0]  w_rsq;

  // Distance squared against radius squared; magnitudes are taken first
  // so the multipliers stay unsigned.
  always_comb begin
    w_dx   = $signed({1'b0, i_px}) - $signed({1'b0, i_cx});
    w_dy   = $signed({1'b0, i_py}) - $signed({1'b0, i_cy});
    w_adx  = w_dx[COORD_W] ? $unsigned(-w_dx) : $unsigned(w_dx);
    w_ady  = w_dy[COORD_W] ? $unsigned(-w_dy) : $unsigned(w_dy);
    w_dist = SQ_W'(w_adx) * SQ_W'(w_adx) + SQ_W'(w_ady) * SQ_W'(w_ady);
    w_rsq  = SQ_W'(i_r) * SQ_W'(i_r);
    o_hit  = (w_dist <= w_rsq);
  end

endmodule

// File: rtl/set_multi_eval.sv
// Set-candidate counter: scans every point of a GRID x GRID lattice,
// LANES points per cycle, tests each against NCIRC circles and counts
// the points whose circle-membership vector selects a 1 in func.
module set_multi_eval
  import set_pkg::*;
#(
  parameter int NCIRC   = DEF_NCIRC,
  parameter int COORD_W = DEF_COORD_W,
  parameter int GRID    = DEF_GRID,
  parameter int LANES   = DEF_LANES,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NCIRC*2*COORD_W-1:0] central,
  input  logic [NCIRC*COORD_W-1:0]   radius,
  input  logic [(1<<NCIRC)-1:0]      func,
  output logic                       busy,
  output logic                       valid,
  output logic [CNT_W-1:0]           candidate
);

  localparam int NPTS     = GRID * GRID;
  localparam int IDX_W    = (NPTS > 1) ? clog2(NPTS) : 1;
  localparam int POP_W    = clog2(LANES + 1);
  localparam int NFUNC    = 1 << NCIRC;
  localparam int LAST_IDX = NPTS - LANES;

  state_t                              r_state;
  logic                                r_busy;
  logic                                r_valid;
  logic [CNT_W-1:0]                    r_cand;
  logic [NCIRC*2*COORD_W-1:0]          r_central;
  logic [NCIRC*COORD_W-1:0]            r_radius;
  logic [NFUNC-1:0]                    r_func;
  logic [IDX_W-1:0]                    r_idx;
  logic [LANES-1:0][NCIRC-1:0]         r_m;
  logic                                r_mValid;
  logic [CNT_W-1:0]                    r_acc;

  logic [LANES-1:0][NCIRC-1:0]         w_hit;
  logic [LANES-1:0]                    w_sel;
  logic [POP_W-1:0]                    w_pop;
  logic                                w_accept;
  logic                                w_lastGroup;

  assign w_accept    = (r_state == IDLE) && en;
  assign w_lastGroup = (r_idx == IDX_W'(LAST_IDX));

  // Stage A point generation and membership tests, plus the stage B
  // func lookup for each lane.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [COORD_W-1:0] w_px;
    logic [COORD_W-1:0] w_py;

    assign w_px = COORD_W'((int'(r_idx) + l) % GRID + 1);
    assign w_py = COORD_W'((int'(r_idx) + l) / GRID + 1);

    for (genvar c = 0; c < NCIRC; c++) begin : g_circ
      circle_hit #(
        .COORD_W(COORD_W)
      ) u_hit (
        .i_px (w_px),
        .i_py (w_py),
        .i_cx (r_central[2*c*COORD_W +: COORD_W]),
        .i_cy (r_central[(2*c+1)*COORD_W +: COORD_W]),
        .i_r  (r_radius[c*COORD_W +: COORD_W]),
        .o_hit(w_hit[l][c])
      );
    end

    assign w_sel[l] = r_func[r_m[l]];
  end

  // Number of selected points in the group currently sitting in stage B.
  always_comb begin
    w_pop = '0;
    for (int l = 0; l < LANES; l++) begin
      w_pop = w_pop + POP_W'(w_sel[l]);
    end
  end

  // Job controller: captures the job, walks the scan counter and
  // publishes the final count with a one-cycle strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_cand    <= '0;
      r_central <= '0;
      r_radius  <= '0;
      r_func    <= '0;
      r_idx     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_valid <= 1'b0;
          if (en) begin
            r_central <= central;
            r_radius  <= radius;
            r_func    <= func;
            r_idx     <= '0;
            r_cand    <= '0;
            r_busy    <= 1'b1;
            r_state   <= SCAN;
          end
        end
        SCAN: begin
          if (w_lastGroup) begin
            r_state <= DRAIN;
          end else begin
            r_idx <= r_idx + IDX_W'(LANES);
          end
        end
        DRAIN: begin
          r_cand  <= r_acc + CNT_W'(w_pop);
          r_valid <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // Pipeline registers: membership vectors from stage A and the running
  // count built up by stage B.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m      <= '0;
      r_mValid <= 1'b0;
      r_acc    <= '0;
    end else begin
      r_m      <= w_hit;
      r_mValid <= (r_state == SCAN);
      if (w_accept) begin
        r_acc <= '0;
      end else if (r_mValid) begin
        r_acc <= r_acc + CNT_W'(w_pop);
      end
    end
  end

  assign busy      = r_busy;
  assign valid     = r_valid;
  assign candidate = r_cand;

endmodule

// File: tb/tb_set_multi_eval.sv
// Self-checking bench for set_multi_eval: a default instance driven with
// directed jobs and a 4-circle / 12x12 / 8-lane instance for a random sweep,
// both checked every cycle against a point-by-point counting model.
module tb_set_multi_eval;

  localparam int S1 = 16;
  localparam int S2 = 18;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        d1_en = 1'b0;
  logic [23:0] d1_central = '0;
  logic [11:0] d1_radius = '0;
  logic [7:0]  d1_func = '0;
  logic        d1_busy;
  logic        d1_valid;
  logic [7:0]  d1_cand;

  logic        d2_en = 1'b0;
  logic [31:0] d2_central = '0;
  logic [15:0] d2_radius = '0;
  logic [15:0] d2_func = '0;
  logic        d2_busy;
  logic        d2_valid;
  logic [7:0]  d2_cand;

  int nChecks = 0;
  int nFail = 0;

  int mCnt[2];
  int expCand[2];
  int pend[2];

  always #5 clk = ~clk;

  set_multi_eval u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .en       (d1_en),
    .central  (d1_central),
    .radius   (d1_radius),
    .func     (d1_func),
    .busy     (d1_busy),
    .valid    (d1_valid),
    .candidate(d1_cand)
  );

  set_multi_eval #(
    .NCIRC  (4),
    .COORD_W(4),
    .GRID   (12),
    .LANES  (8),
    .CNT_W  (8)
  ) u_dut2 (
    .clk      (clk),
    .rst      (rst),
    .en       (d2_en),
    .central  (d2_central),
    .radius   (d2_radius),
    .func     (d2_func),
    .busy     (d2_busy),
    .valid    (d2_valid),
    .candidate(d2_cand)
  );

  // Count lattice points whose membership vector selects a 1 in fn.
  function automatic int countSet(input int nc, input int cw, input int grid,
                                  input logic [63:0] cen, input logic [63:0] rad,
                                  input logic [15:0] fn);
    int total;
    int msk;
    int m;
    int cx;
    int cy;
    int r;
    int d;
    total = 0;
    msk = (1 << cw) - 1;
    for (int y = 1; y <= grid; y++) begin
      for (int x = 1; x <= grid; x++) begin
        m = 0;
        for (int i = 0; i < nc; i++) begin
          cx = int'((cen >> (2 * i * cw)) & 64'(msk));
          cy = int'((cen >> ((2 * i + 1) * cw)) & 64'(msk));
          r  = int'((rad >> (i * cw)) & 64'(msk));
          d  = (x - cx) * (x - cx) + (y - cy) * (y - cy);
          if (d <= r * r) m = m | (1 << i);
        end
        if (fn[m]) total++;
      end
    end
    return total;
  endfunction

  function automatic logic [23:0] cen3(input int ax, input int ay, input int bx, input int by);
    return {8'd0, 4'(by), 4'(bx), 4'(ay), 4'(ax)};
  endfunction

  function automatic logic [11:0] rad3(input int ra, input int rb);
    return {4'd0, 4'(rb), 4'(ra)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  // Job timeline model: a job accepted at an idle edge is busy for S+2
  // cycles, strobes valid in the last of them and shows its count from then on.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mCnt[0] <= 0;
      mCnt[1] <= 0;
      expCand[0] <= 0;
      expCand[1] <= 0;
    end else begin
      if (mCnt[0] == 0) begin
        if (d1_en) begin
          mCnt[0] <= 1;
          expCand[0] <= 0;
          pend[0] <= countSet(3, 4, 8, 64'(d1_central), 64'(d1_radius), 16'(d1_func));
        end
      end else if (mCnt[0] == S1 + 2) begin
        mCnt[0] <= 0;
      end else begin
        mCnt[0] <= mCnt[0] + 1;
        if (mCnt[0] + 1 == S1 + 2) expCand[0] <= pend[0];
      end
      if (mCnt[1] == 0) begin
        if (d2_en) begin
          mCnt[1] <= 1;
          expCand[1] <= 0;
          pend[1] <= countSet(4, 4, 12, 64'(d2_central), 64'(d2_radius), d2_func);
        end
      end else if (mCnt[1] == S2 + 2) begin
        mCnt[1] <= 0;
      end else begin
        mCnt[1] <= mCnt[1] + 1;
        if (mCnt[1] + 1 == S2 + 2) expCand[1] <= pend[1];
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    checkOutput("d1 busy", 64'(d1_busy), 64'(mCnt[0] != 0));
    checkOutput("d1 valid", 64'(d1_valid), 64'(mCnt[0] == S1 + 2));
    checkOutput("d1 candidate", 64'(d1_cand), 64'(expCand[0]));
    checkOutput("d2 busy", 64'(d2_busy), 64'(mCnt[1] != 0));
    checkOutput("d2 valid", 64'(d2_valid), 64'(mCnt[1] == S2 + 2));
    checkOutput("d2 candidate", 64'(d2_cand), 64'(expCand[1]));
  end

  // Run one job on the default instance; called at a falling edge while idle.
  task automatic applyStimulus(input string name, input logic [23:0] cen,
                               input logic [11:0] rad, input logic [7:0] fn,
                               input int expCount);
    int got;
    checkOutput({name, " model"}, 64'(countSet(3, 4, 8, 64'(cen), 64'(rad), 16'(fn))), 64'(expCount));
    d1_central = cen;
    d1_radius  = rad;
    d1_func    = fn;
    d1_en      = 1'b1;
    got = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) d1_en = 1'b0;
      if (d1_valid === 1'b1) begin
        got = k;
        break;
      end
    end
    checkOutput({name, " valid cycle"}, 64'(got), 64'(S1 + 2));
    checkOutput({name, " candidate"}, 64'(d1_cand), 64'(expCount));
    @(negedge clk);
    checkOutput({name, " busy after"}, 64'(d1_busy), 64'd0);
  endtask

  // Run one job on the wide instance; called at a falling edge while idle.
  task automatic applyStimulus2(input string name, input logic [31:0] cen,
                                input logic [15:0] rad, input logic [15:0] fn,
                                input int expCount);
    int got;
    d2_central = cen;
    d2_radius  = rad;
    d2_func    = fn;
    d2_en      = 1'b1;
    got = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) d2_en = 1'b0;
      if (d2_valid === 1'b1) begin
        got = k;
        break;
      end
    end
    checkOutput({name, " valid cycle"}, 64'(got), 64'(S2 + 2));
    checkOutput({name, " candidate"}, 64'(d2_cand), 64'(expCount));
    @(negedge clk);
  endtask

  initial begin
    int nValid;
    int firstV;
    int secondV;
    logic [31:0] rc;
    logic [15:0] rr;
    logic [15:0] rf;

    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset busy", 64'(d1_busy), 64'd0);
    checkOutput("reset valid", 64'(d1_valid), 64'd0);
    checkOutput("reset candidate", 64'(d1_cand), 64'd0);

    applyStimulus("A r1 0xAA", cen3(4, 4, 0, 0), rad3(1, 0), 8'hAA, 5);
    applyStimulus("corner r2", cen3(1, 1, 0, 0), rad3(2, 0), 8'hAA, 6);
    applyStimulus("A and B", cen3(4, 4, 5, 4), rad3(1, 1), 8'h88, 2);
    applyStimulus("A xor B", cen3(4, 4, 5, 4), rad3(1, 1), 8'h66, 6);
    applyStimulus("all", cen3(4, 4, 5, 4), rad3(1, 1), 8'hFF, 64);
    applyStimulus("none", cen3(4, 4, 5, 4), rad3(1, 1), 8'h00, 0);

    // en during SCAN and DONE must be ignored; en right after DONE starts a new job.
    d1_central = cen3(4, 4, 0, 0);
    d1_radius  = rad3(1, 0);
    d1_func    = 8'hAA;
    d1_en      = 1'b1;
    nValid = 0;
    firstV = 0;
    secondV = 0;
    for (int off = 1; off <= 45; off++) begin
      @(negedge clk);
      d1_en = 1'b0;
      if (d1_valid === 1'b1) begin
        nValid++;
        if (firstV == 0) begin
          firstV = off;
          checkOutput("ignore first candidate", 64'(d1_cand), 64'd5);
        end else if (secondV == 0) begin
          secondV = off;
        end
      end
      if (off == 5) begin
        d1_en = 1'b1;
        d1_radius = rad3(2, 0);
        d1_func = 8'hFF;
      end
      if (off == 18 || off == 19) begin
        d1_en = 1'b1;
        d1_radius = rad3(2, 0);
        d1_func = 8'hAA;
      end
      if (secondV != 0) break;
    end
    checkOutput("ignore first valid", 64'(firstV), 64'd18);
    checkOutput("ignore second valid", 64'(secondV), 64'd37);
    checkOutput("ignore valid count", 64'(nValid), 64'd2);
    checkOutput("ignore second candidate", 64'(d1_cand), 64'd13);

    // Reset while idle clears a held result.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 checkOutput("idle rst candidate", 64'(d1_cand), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a job aborts it without a result.
    d1_central = cen3(4, 4, 0, 0);
    d1_radius  = rad3(2, 0);
    d1_func    = 8'hAA;
    d1_en      = 1'b1;
    for (int off = 1; off <= 5; off++) begin
      @(negedge clk);
      d1_en = 1'b0;
    end
    checkOutput("mid-job busy before rst", 64'(d1_busy), 64'd1);
    #2 rst = 1'b1;
    #1 checkOutput("rst busy", 64'(d1_busy), 64'd0);
    checkOutput("rst valid", 64'(d1_valid), 64'd0);
    checkOutput("rst candidate", 64'(d1_cand), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    nValid = 0;
    for (int off = 0; off < 25; off++) begin
      @(negedge clk);
      if (d1_valid === 1'b1) nValid++;
    end
    checkOutput("no valid after rst", 64'(nValid), 64'd0);
    applyStimulus("after rst", cen3(4, 4, 5, 4), rad3(1, 1), 8'h66, 6);

    // Wide instance: one hand-checked job, then a random sweep.
    checkOutput("d2 r3 model", 64'(countSet(4, 4, 12, 64'(32'h66), 64'(16'h3), 16'hAAAA)), 64'd29);
    applyStimulus2("d2 r3", 32'h0000_0066, 16'h0003, 16'hAAAA, 29);
    applyStimulus2("d2 all", 32'h0000_0066, 16'h0003, 16'hFFFF, 144);
    for (int j = 0; j < 10; j++) begin
      rc = $urandom;
      rr = 16'($urandom_range(0, 65535));
      rf = 16'($urandom_range(0, 65535));
      applyStimulus2("d2 random", rc, rr, rf,
                     countSet(4, 4, 12, 64'(rc), 64'(rr), rf));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/set_multi_eval.md
# set_multi_eval

Parametrised set-candidate counter. Up to NCIRC circles on a GRID x GRID integer lattice are tested against every lattice point, LANES points per cycle. A point counts when a programmable truth-table mask, indexed by its circle-membership vector, is 1. It is the next-generation set-evaluation engine: arbitrary circle count, arbitrary set function and parallel lanes replace the fixed 3-circle, 2-bit-mode datapath.

## Interface
Parameters:
- NCIRC, 3, number of circles (1..4)
- COORD_W, 4, width of one coordinate / radius field
- GRID, 8, lattice is x,y in 1..GRID; must satisfy GRID <= 2^COORD_W-1
- LANES, 4, points evaluated per cycle; power of two dividing GRID*GRID
- CNT_W, 8, candidate width; must satisfy 2^CNT_W > GRID*GRID

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  start request; sampled only while busy=0
- central  in  NCIRC*2*COORD_W  circle i: x at [2i*COORD_W +: COORD_W], y at [(2i+1)*COORD_W +: COORD_W]
- radius  in  NCIRC*COORD_W  circle i radius at [i*COORD_W +: COORD_W]
- func  in  2^NCIRC  set function mask; point counted iff func[m]=1, where m[i]=1 when the point is inside circle i
- busy  out  1  job in progress
- valid  out  1  one-cycle result strobe
- candidate  out  CNT_W  count of selected points

## Operation
- Membership: (px-cx)^2 + (py-cy)^2 <= r^2.
  - Differences are signed, COORD_W+1 bits.
  - Squares and the sum are unsigned, 2*COORD_W+3 bits. No truncation.
- Centres are allowed off-lattice (0, or >GRID). Points outside 1..GRID never count.
- r=0 selects only the centre point.
- On en accept, central, radius and func are captured into registers. Input changes during the job have no effect.
- Scan counter walks point index 0..GRID*GRID-1, LANES consecutive indices per cycle. Index k maps to x = k mod GRID + 1, y = k / GRID + 1.
- Pipeline:
  - Stage A: point generation plus NCIRC*LANES membership tests, registered into an m-vector register per lane.
  - Stage B: func lookup per lane, popcount of the LANES selected bits, added into the accumulator.
- FSM:
  - IDLE: busy=0. On en -> SCAN; the accumulator and candidate clear.
  - SCAN: S = GRID*GRID/LANES cycles. Counter increments by LANES. After the last group -> DRAIN.
  - DRAIN: 1 cycle flushing stage B -> DONE.
  - DONE: 1 cycle; valid=1, candidate=final count -> IDLE.
- candidate holds its value after DONE until the next accepted en.
- en is ignored while busy=1, including in the DONE cycle.
- rst at any time: the FSM goes to IDLE and all registers clear immediately. No partial result is ever reported.

## Timing
- Reset values: busy=0, valid=0, candidate=0.
- en sampled high at edge of cycle T (IDLE):
  - busy=1 from T+1 through T+S+2 inclusive.
  - valid=1 only in cycle T+S+2.
  - busy=0 at T+S+3.
- Defaults (S=16): valid at T+18.
- Back-to-back: earliest next accept is the en sampled in cycle T+S+3. Its valid comes S+2 cycles later, with no gap cycles beyond that.
- The accumulator never saturates; the CNT_W constraint guarantees no overflow.

## Structure
- Shared package set_pkg holds:
  - the state enum (IDLE, SCAN, DRAIN, DONE)
  - default parameter constants
  - a clog2 function for the scan-counter width
- Sub-module circle_hit: combinational single point vs single circle test. Instantiated NCIRC*LANES times.
- Top level: FSM, capture registers, scan counter, m-vector pipeline registers, popcount/accumulate.

## Test plan
Defaults throughout; circle A = index 0, B = index 1.
- A (4,4) r=1, func=0xAA -> candidate=5, valid exactly at T+18, busy low at T+19.
- A (1,1) r=2, func=0xAA (corner clipping) -> 6.
- A (4,4) r=1, B (5,4) r=1:
  - func=0x88 (A∩B) -> 2
  - func=0x66 (A xor B) -> 6
  - func=0xFF -> 64
  - func=0x00 -> 0
- en pulsed during SCAN and during DONE -> ignored, single valid. en at T+19 with A (4,4) r=2, func=0xAA -> second valid at T+37, candidate=13.
- rst asserted at T+5 -> busy, valid and candidate 0 immediately, no valid. A new en then completes normally with the correct count.
- Random sweep vs. reference model for NCIRC=4, GRID=12, LANES=8, COORD_W=4, with random centres 0..15, radii 0..15 and func masks -> exact count match.
